spi_cfg_sequencer: RTL

Write-only SPI controller that turns queued register-write requests into 16-bit frames for the on-chip SPI register-file peripheral. Each frame updates one peripheral register: output enables, PWM enables or duty cycle. The block sits between local configuration logic (test sequencer, boot loader) and the peripheral's nCS/SCLK/COPI pins. It buffers up to four requests, rejects unmapped addresses, and paces SCLK slowly enough for the peripheral's 2-flop input synchronisers.

---
 rtl/spi_regmap_pkg.sv | 41 ++++
 rtl/spi_cfg_sequencer_sync_fifo.sv | 62 ++++++
 rtl/spi_cfg_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_regmap_pkg.sv
// Register map, frame geometry and sequencer state encoding shared by the SPI
// configuration sequencer and anything that models the peripheral side.
package spi_regmap_pkg;

  localparam logic [6:0] EN_OUT_LO = 7'h00;
  localparam logic [6:0] EN_OUT_HI = 7'h01;
  localparam logic [6:0] EN_PWM_LO = 7'h02;
  localparam logic [6:0] EN_PWM_HI = 7'h03;
  localparam logic [6:0] PWM_DUTY  = 7'h04;
  localparam logic [6:0] ADDR_MAX  = PWM_DUTY;

  localparam int FRAME_W = 16;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } spi_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_GAP
  } seq_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic addr_mapped(input logic [6:0] addr);
    return (addr <= ADDR_MAX);
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_sync_fifo.sv
// Single-clock request queue with a registered head stage: an entry becomes
// visible on rd_data one cycle after it is written, and level counts the head.
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic             do_push, do_pop, mem_has, load_head;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && rd_valid;
  // Entries still in the array are level minus the head slot.
  assign mem_has   = (level != LW'(rd_valid));
  assign load_head = mem_has && (!rd_valid || do_pop);

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (do_push)   wr_ptr <= wr_ptr + 1'b1;
      if (load_head) rd_ptr <= rd_ptr + 1'b1;
      if (load_head)   rd_valid <= 1'b1;
      else if (do_pop) rd_valid <= 1'b0;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage and the head data carry no reset; validity is tracked by
  // level/rd_valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push)   mem[wr_ptr] <= wr_data;
    if (load_head) rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Write-only SPI master: pops queued register writes and shifts them out as
// {1, addr[6:0], data[7:0]} mode-0 frames paced for a synchronising peripheral.
module spi_cfg_sequencer
  import spi_regmap_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 4,
  parameter int CS_HOLD    = 4,
  parameter int CS_GAP     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done,
  output logic       err_addr
);

  localparam int PH_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP)) + 1;
  localparam logic [PH_W-1:0] DIV_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(CS_GAP - 1);
  localparam logic [4:0]      LAST_BIT   = 5'(FRAME_W - 1);
  localparam logic [4:0]      ALL_BITS   = 5'(FRAME_W);

  seq_state_e         state, state_nxt;
  logic [PH_W-1:0]    phase, phase_nxt;
  logic [4:0]         bit_cnt, bit_cnt_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt, frame;
  logic               ncs_nxt, sclk_nxt, copi_nxt, done_nxt, err_nxt;
  spi_req_t           req_in, head;
  logic               head_valid, fifo_full, fifo_empty, pop;

  assign req_in    = '{addr: req_addr, data: req_data};
  assign req_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign frame     = {1'b1, head};

  sync_fifo #(
    .WIDTH($bits(spi_req_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_valid),
    .wr_data (req_in),
    .pop     (pop),
    .rd_data (head),
    .rd_valid(head_valid),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ncs_nxt     = nCS;
    sclk_nxt    = SCLK;
    copi_nxt    = COPI;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    pop         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        phase_nxt = '0;
        if (head_valid) begin
          pop = 1'b1;
          if (addr_mapped(head.addr)) begin
            shreg_nxt   = frame;
            copi_nxt    = frame[FRAME_W-1];
            ncs_nxt     = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = ST_SETUP;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_SETUP: if (phase == SETUP_LAST) begin
        phase_nxt = '0;
        sclk_nxt  = 1'b1;
        state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: if (phase == DIV_LAST) begin
        phase_nxt   = '0;
        sclk_nxt    = 1'b0;
        bit_cnt_nxt = bit_cnt + 1'b1;
        // After the last bit COPI keeps bit 0 through HOLD.
        if (bit_cnt != LAST_BIT) begin
          shreg_nxt = shreg << 1;
          copi_nxt  = shreg[FRAME_W-2];
        end
        state_nxt = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: if (phase == DIV_LAST) begin
        phase_nxt = '0;
        if (bit_cnt == ALL_BITS) begin
          state_nxt = ST_HOLD;
        end else begin
          sclk_nxt  = 1'b1;
          state_nxt = ST_SHIFT_HI;
        end
      end
      ST_HOLD: if (phase == HOLD_LAST) begin
        phase_nxt = '0;
        ncs_nxt   = 1'b1;
        copi_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = ST_GAP;
      end
      ST_GAP: if (phase == GAP_LAST) begin
        phase_nxt = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      nCS      <= 1'b1;
      SCLK     <= 1'b0;
      COPI     <= 1'b0;
      done     <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      nCS      <= ncs_nxt;
      SCLK     <= sclk_nxt;
      COPI     <= copi_nxt;
      done     <= done_nxt;
      err_addr <= err_nxt;
    end
  end

endmodule
